multicycle_control_unit: RTL and testbench

- Control FSM for the multicycle RISC-V datapath. It is the successor of the single-cycle decoder and drives a shared ALU, a unified instruction/data memory port and the IR/PC write enables.
- Supports lw, sw, R-type and I-type add/sub/and/or/slt, beq, optional bne, and jal.
- Adds a memory-ready stall handshake and a sticky illegal-instruction trap.

---
 rtl/multicycle_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RISC-V datapath: sequences fetch/decode/execute/writeback,
// stalls memory states on mem_ready and latches a sticky trap on illegal encodings.
module multicycle_control_unit #(
    parameter int unsigned ALUC_W   = 3,
    parameter bit          EN_BNE   = 1'b1,
    parameter bit          EN_STALL = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              adr_src,
    output logic              mem_write,
    output logic              ir_write,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        imm_src,
    output logic              reg_write,
    output logic [ALUC_W-1:0] alu_control,
    output logic              instr_done,
    output logic              illegal
);

    if (ALUC_W < 3) begin : g_aluc_w_check
        $error("ALUC_W must be at least 3");
    end

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWr,
        StExecR, StExecI, StAluWb, StBranch, StJal, StTrap
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    state_e     state_q, state_d;
    logic       rdy;
    logic [2:0] f3_alu;
    logic       f3_ok;
    logic       br_ok;
    logic       br_take;

    logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c, done_c, illegal_c;
    logic [2:0] alu_c;

    assign rdy = EN_STALL ? mem_ready : 1'b1;

    // funct3 decode shared by EXECR and EXECI; only R-type honours funct7b5
    always_comb begin
        f3_alu = AluAdd;
        f3_ok  = 1'b1;
        case (funct3)
            3'b000:  f3_alu = (funct7b5 && (state_q == StExecR)) ? AluSub : AluAdd;
            3'b111:  f3_alu = AluAnd;
            3'b110:  f3_alu = AluOr;
            3'b010:  f3_alu = AluSlt;
            default: f3_ok  = 1'b0;
        endcase
    end

    assign br_ok   = (funct3 == 3'b000) || (EN_BNE && (funct3 == 3'b001));
    assign br_take = (funct3 == 3'b000) ? zero : ~zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        done_c      = 1'b0;
        illegal_c   = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_c       = AluAdd;
        unique case (state_q)
            StFetch: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = rdy;
                pc_write_c = rdy;
                if (rdy) state_d = StDecode;
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (op)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecR;
                    7'b0010011:             state_d = StExecI;
                    7'b1100011:             state_d = StBranch;
                    7'b1101111:             state_d = StJal;
                    default:                state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == 7'b0100011) begin
                    imm_src = 2'b01;
                    state_d = StMemWr;
                end else begin
                    state_d = StMemRead;
                end
            end
            StMemRead: begin
                adr_src = 1'b1;
                if (rdy) state_d = StMemWb;
            end
            StMemWb: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = StFetch;
            end
            StMemWr: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                done_c      = rdy;
                if (rdy) state_d = StFetch;
            end
            StExecR, StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = (state_q == StExecI) ? 2'b01 : 2'b00;
                alu_c     = f3_alu;
                state_d   = f3_ok ? StAluWb : StTrap;
            end
            StAluWb: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = StFetch;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                alu_c     = AluSub;
                if (br_ok) begin
                    pc_write_c = br_take;
                    done_c     = 1'b1;
                    state_d    = StFetch;
                end else begin
                    state_d    = StTrap;
                end
            end
            StJal: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                imm_src    = 2'b11;
                pc_write_c = 1'b1;
                state_d    = StAluWb;
            end
            StTrap: begin
                illegal_c = 1'b1;
            end
            default: state_d = StTrap;
        endcase
    end

    // Gate every write/pulse with reset so nothing commits once reset_n falls
    assign pc_write    = pc_write_c  & reset_n;
    assign ir_write    = ir_write_c  & reset_n;
    assign mem_write   = mem_write_c & reset_n;
    assign reg_write   = reg_write_c & reset_n;
    assign instr_done  = done_c      & reset_n;
    assign illegal     = illegal_c   & reset_n;
    assign alu_control = ALUC_W'(alu_c);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class cycle by cycle and
// compares the packed output vector against hand-written per-state constants.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .ALUC_W  (3),
        .EN_BNE  (1'b1),
        .EN_STALL(1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .alu_control(alu_control),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // {adr_src, mem_write, ir_write, pc_write, reg_write, instr_done, illegal,
    //  result_src, alu_src_a, alu_src_b, imm_src, alu_control}
    logic [17:0] outs;
    assign outs = {adr_src, mem_write, ir_write, pc_write, reg_write, instr_done, illegal,
                   result_src, alu_src_a, alu_src_b, imm_src, alu_control};

    localparam logic [17:0] V_RESET     = 18'b0_0_0_0_0_0_0_10_00_10_00_000;
    localparam logic [17:0] V_FETCH     = 18'b0_0_1_1_0_0_0_10_00_10_00_000;
    localparam logic [17:0] V_FETCH_W   = 18'b0_0_0_0_0_0_0_10_00_10_00_000;
    localparam logic [17:0] V_DECODE    = 18'b0_0_0_0_0_0_0_00_01_01_10_000;
    localparam logic [17:0] V_EXECR_ADD = 18'b0_0_0_0_0_0_0_00_10_00_00_000;
    localparam logic [17:0] V_EXECR_SUB = 18'b0_0_0_0_0_0_0_00_10_00_00_001;
    localparam logic [17:0] V_EXECI_SLT = 18'b0_0_0_0_0_0_0_00_10_01_00_100;
    localparam logic [17:0] V_ALUWB     = 18'b0_0_0_0_1_1_0_00_00_00_00_000;
    localparam logic [17:0] V_MEMADR_LW = 18'b0_0_0_0_0_0_0_00_10_01_00_000;
    localparam logic [17:0] V_MEMADR_SW = 18'b0_0_0_0_0_0_0_00_10_01_01_000;
    localparam logic [17:0] V_MEMREAD   = 18'b1_0_0_0_0_0_0_00_00_00_00_000;
    localparam logic [17:0] V_MEMWB     = 18'b0_0_0_0_1_1_0_01_00_00_00_000;
    localparam logic [17:0] V_MEMWR_W   = 18'b1_1_0_0_0_0_0_00_00_00_00_000;
    localparam logic [17:0] V_MEMWR_R   = 18'b1_1_0_0_0_1_0_00_00_00_00_000;
    localparam logic [17:0] V_BR_TAKEN  = 18'b0_0_0_1_0_1_0_00_10_00_00_001;
    localparam logic [17:0] V_BR_NOT    = 18'b0_0_0_0_0_1_0_00_10_00_00_001;
    localparam logic [17:0] V_JAL       = 18'b0_0_0_1_0_0_0_00_01_10_11_000;
    localparam logic [17:0] V_TRAP      = 18'b0_0_0_0_0_0_1_00_00_00_00_000;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Let inputs settle, compare this cycle's outputs, then advance to just after the next edge
    task automatic cyc(input string tag, input logic [17:0] exp);
        #1;
        check(tag, 32'(outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        set_instr(7'b0000000, 3'b000, 1'b0);
        #2;
        check("reset_outputs", 32'(outs), 32'(V_RESET));
        #10;
        reset_n = 1'b1;

        // add x3,x1,x2
        set_instr(7'b0110011, 3'b000, 1'b0);
        cyc("add.fetch", V_FETCH);
        cyc("add.decode", V_DECODE);
        cyc("add.execr", V_EXECR_ADD);
        cyc("add.aluwb", V_ALUWB);

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc("sub.fetch", V_FETCH);
        cyc("sub.decode", V_DECODE);
        cyc("sub.execr", V_EXECR_SUB);
        cyc("sub.aluwb", V_ALUWB);

        // slti, funct7b5 set but must be ignored by the I-type map
        set_instr(7'b0010011, 3'b010, 1'b1);
        cyc("slti.fetch", V_FETCH);
        cyc("slti.decode", V_DECODE);
        cyc("slti.execi", V_EXECI_SLT);
        cyc("slti.aluwb", V_ALUWB);

        // lw, 3 stall cycles in MEMREAD -> 8 cycles total
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("lw.fetch", V_FETCH);
        cyc("lw.decode", V_DECODE);
        cyc("lw.memadr", V_MEMADR_LW);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("lw.memread_wait%0d", i), V_MEMREAD);
        mem_ready = 1'b1;
        cyc("lw.memread_rdy", V_MEMREAD);
        cyc("lw.memwb", V_MEMWB);

        // sw with a fetch stall, then 2 stall cycles in MEMWR
        set_instr(7'b0100011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        cyc("sw.fetch_wait", V_FETCH_W);
        mem_ready = 1'b1;
        cyc("sw.fetch", V_FETCH);
        cyc("sw.decode", V_DECODE);
        cyc("sw.memadr", V_MEMADR_SW);
        mem_ready = 1'b0;
        cyc("sw.memwr_wait0", V_MEMWR_W);
        cyc("sw.memwr_wait1", V_MEMWR_W);
        mem_ready = 1'b1;
        cyc("sw.memwr_rdy", V_MEMWR_R);

        // beq taken / not taken, bne taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        cyc("beq1.fetch", V_FETCH);
        cyc("beq1.decode", V_DECODE);
        cyc("beq1.branch", V_BR_TAKEN);
        zero = 1'b0;
        cyc("beq0.fetch", V_FETCH);
        cyc("beq0.decode", V_DECODE);
        cyc("beq0.branch", V_BR_NOT);
        set_instr(7'b1100011, 3'b001, 1'b0);
        cyc("bne.fetch", V_FETCH);
        cyc("bne.decode", V_DECODE);
        cyc("bne.branch", V_BR_TAKEN);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal.fetch", V_FETCH);
        cyc("jal.decode", V_DECODE);
        cyc("jal.jal", V_JAL);
        cyc("jal.aluwb", V_ALUWB);

        // reset during a stalled store must kill mem_write immediately
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("swabort.fetch", V_FETCH);
        cyc("swabort.decode", V_DECODE);
        cyc("swabort.memadr", V_MEMADR_SW);
        mem_ready = 1'b0;
        #1;
        check("swabort.memwr", 32'(outs), 32'(V_MEMWR_W));
        reset_n = 1'b0;
        #1;
        check("swabort.in_reset", 32'(outs), 32'(V_RESET));
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        cyc("swabort.fetch_after", V_FETCH);

        // illegal opcode -> sticky trap, cleared only by reset
        set_instr(7'b1110011, 3'b000, 1'b0);
        cyc("ecall.decode", V_DECODE);
        cyc("ecall.trap0", V_TRAP);
        mem_ready = 1'b0;
        cyc("ecall.trap1", V_TRAP);
        set_instr(7'b0110011, 3'b000, 1'b0);
        mem_ready = 1'b1;
        cyc("ecall.trap2", V_TRAP);
        reset_n = 1'b0;
        #1;
        check("ecall.in_reset", 32'(outs), 32'(V_RESET));
        reset_n = 1'b1;

        // R-type funct3=001 is not supported -> trap after EXECR
        set_instr(7'b0110011, 3'b001, 1'b0);
        cyc("rbad.fetch", V_FETCH);
        cyc("rbad.decode", V_DECODE);
        tick();
        cyc("rbad.trap0", V_TRAP);
        cyc("rbad.trap1", V_TRAP);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of test expected finish before 20000");
        $fatal(1);
    end

endmodule
